// File: rtl/sift_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sift_mem_pkg
// Brief    : Shared SRAM/pixel geometry and the frame reader state type.
// Revision : 1.0 - initial release
// ============================================================================
package sift_mem_pkg;

  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_DATA_W     = 32;
  localparam int PIXEL_W         = 8;
  localparam int PIXELS_PER_WORD = 4;

  // Pixel counter covers up to 2^20 pixels per frame.
  localparam int PIX_CNT_W  = 20;
  // One bit wider than the SRAM address so a full 2^20-pixel frame
  // (2^18 words) still has a representable word total.
  localparam int WORD_CNT_W = SRAM_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE      = 2'd2,
    DONE_WAIT = 2'd3
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/pixel_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_word_fifo
// Brief    : Synchronous FIFO holding SRAM read words ahead of the unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != DEPTH_C) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/image_buffer_pixel_reader.sv
`default_nettype none
// ============================================================================
// Module   : image_buffer_pixel_reader
// Brief    : Streams one 8-bit grayscale frame out of ZBT SRAM through the
//            arbiter R1 read port, unpacking 32-bit words into pixels.
// Revision : 1.0 - initial release
// ============================================================================
module image_buffer_pixel_reader
  import sift_mem_pkg::*;
#(
  parameter int unsigned                N_PIXEL    = 480000,
  parameter logic [SRAM_ADDR_W-1:0]     BASE_ADDR  = 18'd0,
  parameter int unsigned                FIFO_DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   start_ack,
  output logic                   done,
  input  logic                   done_ack,
  output logic [SRAM_ADDR_W-1:0] addr,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  input  logic [SRAM_DATA_W-1:0] data,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [PIXEL_W-1:0]     pixel,
  output logic                   pixel_valid,
  input  logic                   pixel_ready
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BYTE_W = $clog2(PIXELS_PER_WORD);
  localparam logic [WORD_CNT_W-1:0] TOTAL_WORDS =
    WORD_CNT_W'((N_PIXEL + PIXELS_PER_WORD - 1) / PIXELS_PER_WORD);
  localparam logic [PIX_CNT_W-1:0]  LAST_PIX  = PIX_CNT_W'(N_PIXEL - 1);
  localparam logic [BYTE_W-1:0]     LAST_BYTE = BYTE_W'(PIXELS_PER_WORD - 1);
  localparam logic [CNT_W:0]        CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

  rd_state_e                state_q, state_d;
  logic                     start_ack_q, start_ack_d;
  logic                     done_q, done_d;
  logic [SRAM_ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]         outstanding_q, outstanding_d;
  logic [SRAM_DATA_W-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]        byte_idx_q, byte_idx_d;
  logic                     pix_valid_q, pix_valid_d;
  logic [PIX_CNT_W-1:0]     pix_cnt_q, pix_cnt_d;

  logic                     frame_start;
  logic                     addr_fire, data_accept, pix_fire;
  logic                     pix_last, word_end, fifo_pop;
  logic [CNT_W:0]           credit_sum;
  logic [SRAM_DATA_W-1:0]   fifo_dout;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_full, fifo_empty;

  // Handshake qualifiers shared by the FSM, issuer and unpacker.
  always_comb begin
    credit_sum  = {1'b0, outstanding_q} + {1'b0, fifo_count};
    addr_valid  = (state_q == RUN) && (issued_q < TOTAL_WORDS) && (credit_sum < CREDITS);
    addr_fire   = addr_valid && addr_ready;
    // A return with nothing outstanding predates the last reset: drop it.
    data_accept = data_valid && (outstanding_q != '0);
    pix_fire    = pix_valid_q && pixel_ready;
    pix_last    = (pix_cnt_q == LAST_PIX);
    // A word ends after its top byte, or early on the frame's final pixel.
    word_end    = (byte_idx_q == LAST_BYTE) || pix_last;
    fifo_pop    = (!pix_valid_q || (pix_fire && word_end)) && !fifo_empty;
  end

  // Frame control FSM with 4-phase start and done handshakes.
  always_comb begin
    state_d     = state_q;
    start_ack_d = start_ack_q;
    done_d      = done_q;
    frame_start = 1'b0;
    if (!start) begin
      start_ack_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        // Requiring start_ack low forces start to drop before a new frame.
        if (start && !start_ack_q) begin
          state_d     = RUN;
          start_ack_d = 1'b1;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (pix_fire && pix_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (done_ack) begin
          state_d = DONE_WAIT;
          done_d  = 1'b0;
        end
      end
      DONE_WAIT: begin
        if (!done_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address issue and read credit accounting.
  always_comb begin
    addr_d   = addr_q;
    issued_d = issued_q;
    if (frame_start) begin
      addr_d   = BASE_ADDR;
      issued_d = '0;
    end else if (addr_fire) begin
      addr_d   = addr_q + 1'b1;
      issued_d = issued_q + 1'b1;
    end
    case ({addr_fire, data_accept})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Unpacker: holding register walks bytes low to high, refilling back-to-back.
  always_comb begin
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    pix_valid_d = pix_valid_q;
    pix_cnt_d   = pix_cnt_q;
    if (fifo_pop) begin
      word_d      = fifo_dout;
      byte_idx_d  = '0;
      pix_valid_d = 1'b1;
    end else if (pix_fire) begin
      if (word_end) begin
        pix_valid_d = 1'b0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
    if (frame_start) begin
      pix_cnt_d = '0;
    end else if (pix_fire) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end
  end

  // State registers; reset aborts any frame in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      start_ack_q   <= 1'b0;
      done_q        <= 1'b0;
      addr_q        <= BASE_ADDR;
      issued_q      <= '0;
      outstanding_q <= '0;
      word_q        <= '0;
      byte_idx_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      start_ack_q   <= start_ack_d;
      done_q        <= done_d;
      addr_q        <= addr_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      word_q        <= word_d;
      byte_idx_q    <= byte_idx_d;
      pix_valid_q   <= pix_valid_d;
      pix_cnt_q     <= pix_cnt_d;
    end
  end

  pixel_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SRAM_DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (data_accept),
    .din     (data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Credits bound outstanding+stored words to the FIFO depth, so a push
  // into a full FIFO means the accounting is broken.
  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
    !(data_accept && fifo_full && !fifo_pop));

  assign start_ack   = start_ack_q;
  assign done        = done_q;
  assign addr        = addr_q;
  assign data_ready  = 1'b1;
  assign pixel       = word_q[byte_idx_q*PIXEL_W +: PIXEL_W];
  assign pixel_valid = pix_valid_q;

endmodule
`default_nettype wire
